// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_unit
// Brief    : Iterative radix-2 MULT/MULTU/DIV/DIVU unit with HI/LO register pair
//            and a stall request towards the hazard logic.
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dato_A,
    input  logic [WIDTH-1:0] dato_B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic             hilo_rd,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t r_state, w_state_next;

    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div0;
    logic [WIDTH-1:0] r_a_raw;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_dz;

    logic             w_signed;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH-1:0] w_div_diff;
    logic             w_ge;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;

    assign w_signed = ~op[0];
    assign w_abs_a  = (w_signed && dato_A[WIDTH-1]) ? -dato_A : dato_A;
    assign w_abs_b  = (w_signed && dato_B[WIDTH-1]) ? -dato_B : dato_B;

    // Multiply: r_d = multiplicand, r_q = multiplier shifting out LSB-first.
    assign w_mul_sum  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_d} : {(WIDTH+1){1'b0}});

    // Divide: r_q = dividend shifting into the partial remainder, r_d = divisor.
    assign w_rem_sh   = {r_acc, r_q[WIDTH-1]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_d});
    assign w_div_diff = w_rem_sh[WIDTH-1:0] - r_d;

    assign w_prod     = {r_acc, r_q};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quot     = r_neg_q ? -r_q : r_q;
    assign w_rem      = r_neg_r ? -r_acc : r_acc;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (r_cnt == CNT_W'(WIDTH-1)) w_state_next = FIX;
            FIX:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_a_raw  <= '0;
            r_d      <= '0;
            r_q      <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (hi_we) r_hi <= dato_A;
                    if (lo_we) r_lo <= dato_A;
                    if (start) begin
                        r_is_div <= op[1];
                        r_neg_q  <= w_signed & (dato_A[WIDTH-1] ^ dato_B[WIDTH-1]);
                        r_neg_r  <= w_signed & dato_A[WIDTH-1];
                        r_div0   <= op[1] & (dato_B == '0);
                        r_a_raw  <= dato_A;
                        r_d      <= op[1] ? w_abs_b : w_abs_a;
                        r_q      <= op[1] ? w_abs_a : w_abs_b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_is_div) begin
                        r_acc <= w_ge ? w_div_diff : w_rem_sh[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], w_ge};
                    end else begin
                        r_acc <= w_mul_sum[WIDTH:1];
                        r_q   <= {w_mul_sum[0], r_q[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    r_done <= 1'b1;
                    if (!r_is_div) begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end else if (r_div0) begin
                        r_hi <= r_a_raw;
                        r_lo <= '1;
                        r_dz <= 1'b1;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi_out   = r_hi;
    assign lo_out   = r_lo;
    assign busy     = (r_state != IDLE);
    assign stall    = busy & (start | hilo_rd | hi_we | lo_we);
    assign done     = r_done;
    assign div_zero = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv_unit
// Brief    : Directed self-checking bench for ex_muldiv_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_unit;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] dato_A;
    logic [WIDTH-1:0] dato_B;
    logic             hi_we;
    logic             lo_we;
    logic             hilo_rd;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             busy;
    logic             stall;
    logic             done;
    logic             div_zero;

    int vectors = 0;
    int errors  = 0;

    ex_muldiv_unit #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .dato_A   (dato_A),
        .dato_B   (dato_B),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .hilo_rd  (hilo_rd),
        .hi_out   (hi_out),
        .lo_out   (lo_out),
        .busy     (busy),
        .stall    (stall),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the rising edge; the DUT samples on the falling edge.
    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        start = 1'b1; op = o; dato_A = a; dato_B = b;
        @(posedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_cycles);
        int k;
        k = 41;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            if (done === 1'b1) begin
                k = i;
                break;
            end
        end
        check({tag, "_latency"}, 64'(k), 64'(exp_cycles));
    endtask

    task automatic run_and_check(input string tag, input logic [1:0] o,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                                 input logic exp_dz);
        start_op(o, a, b);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        wait_done(tag, 33);
        check({tag, "_hi"}, 64'(hi_out), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo_out), 64'(exp_lo));
        check({tag, "_dz"}, 64'(div_zero), 64'(exp_dz));
        check({tag, "_busy_end"}, 64'(busy), 64'd0);
        @(posedge clk);
        check({tag, "_done_pulse"}, 64'({done, div_zero}), 64'd0);
    endtask

    initial begin
        int done_seen;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; dato_A = '0; dato_B = '0;
        hi_we = 1'b0; lo_we = 1'b0; hilo_rd = 1'b0;

        repeat (2) @(posedge clk);
        check("rst_hi", 64'(hi_out), 64'd0);
        check("rst_lo", 64'(lo_out), 64'd0);
        check("rst_flags", 64'({busy, stall, done, div_zero}), 64'd0);
        rst_n = 1'b1;

        run_and_check("mult",  2'b00, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run_and_check("multu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_and_check("div",   2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_and_check("divu",  2'b11, 32'd100,       32'd7,        32'd2,         32'd14,        1'b0);
        run_and_check("divz",  2'b11, 32'h0000_0064, 32'd0,        32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
        run_and_check("ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0);

        // Requests while busy: stall only, no restart, no HI write.
        start_op(2'b01, 32'd3, 32'd7);
        repeat (4) @(posedge clk);
        check("idle_req_nostall", 64'(stall), 64'd0);
        start = 1'b1; op = 2'b11; dato_A = 32'd100; dato_B = 32'd7;
        #1 check("stall_start", 64'(stall), 64'd1);
        @(posedge clk);
        start = 1'b0; hilo_rd = 1'b1;
        #1 check("stall_hilo_rd", 64'(stall), 64'd1);
        @(posedge clk);
        hilo_rd = 1'b0; hi_we = 1'b1; dato_A = 32'hDEAD_BEEF;
        #1 check("stall_hi_we", 64'(stall), 64'd1);
        @(posedge clk);
        hi_we = 1'b0;
        #1 check("stall_clear", 64'(stall), 64'd0);
        wait_done("busyreq", 26);
        check("busyreq_hi", 64'(hi_out), 64'd0);
        check("busyreq_lo", 64'(lo_out), 64'd21);
        @(posedge clk);
        check("busyreq_no_restart", 64'(busy), 64'd0);

        // MTHI / MTLO in IDLE.
        @(posedge clk);
        hi_we = 1'b1; dato_A = 32'h1234_5678;
        @(posedge clk);
        hi_we = 1'b0; lo_we = 1'b1; dato_A = 32'h0BAD_F00D;
        check("mthi", 64'(hi_out), 64'h1234_5678);
        @(posedge clk);
        lo_we = 1'b0;
        check("mtlo", 64'(lo_out), 64'h0BAD_F00D);

        // Reset during RUN aborts the operation.
        start_op(2'b00, 32'd9, 32'd9);
        repeat (10) @(posedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        rst_n = 1'b1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hilo", 64'({hi_out, lo_out}), 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            if (done === 1'b1) done_seen++;
        end
        check("abort_no_done", 64'(done_seen), 64'd0);
        check("abort_hilo_hold", 64'({hi_out, lo_out}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
